// File: rtl/coax_rx_buffer.sv
// rtl/coax_rx_buffer.sv - frame-aware receive FIFO for a coax word receiver
// Tags received words and error codes into 16-bit entries and queues them first-word-fall-through.
module coax_rx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_active,
  input  logic                     rx_error,
  input  logic [9:0]               rx_data,
  input  logic                     rx_strobe,
  input  logic                     read_strobe,
  output logic [15:0]              read_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic                     frame_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RECEIVE, ERROR_HOLD, DISCARD} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_req;
  logic [15:0]     push_entry;
  logic            push_drop;
  logic            push_ok;
  logic            pop_ok;
  logic [AW:0]     count_next;

  // An error code is stored exactly once, on the cycle the error is first seen.
  always_comb begin
    push_req   = 1'b0;
    push_entry = {1'b0, 5'b0, rx_data};
    if (state == IDLE || state == RECEIVE) begin
      if (rx_error) begin
        push_req   = 1'b1;
        push_entry = {1'b1, 5'b0, rx_data};
      end else if (state == RECEIVE && rx_active && rx_strobe) begin
        push_req = 1'b1;
      end
    end
  end

  // A simultaneous pop frees a slot, so a push while full only drops without read_strobe.
  assign push_drop = push_req && full && !read_strobe;
  assign push_ok   = push_req && !push_drop;
  assign pop_ok    = read_strobe && !empty;
  assign read_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_error)       state <= push_drop ? DISCARD : ERROR_HOLD;
          else if (rx_active) state <= RECEIVE;
        end
        RECEIVE: begin
          if (rx_error) begin
            state <= push_drop ? DISCARD : ERROR_HOLD;
          end else if (!rx_active) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (push_drop) begin
            state <= DISCARD;
          end
        end
        default: begin
          if (!rx_error && !rx_active) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
      if (push_drop)           overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb/tb_coax_rx_buffer.sv - self-checking bench for coax_rx_buffer
// Queue-based reference model driven by directed scenarios and a randomized run.
module tb_coax_rx_buffer;

  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_RECV = 1, M_ERR = 2, M_DISC = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_error = 1'b0;
  logic [9:0]  rx_data = '0;
  logic        rx_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic        clear_overflow = 1'b0;
  logic [15:0] read_data;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  int          mode = M_IDLE;
  bit          m_ovf = 1'b0;
  bit          m_fd = 1'b0;

  coax_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx_active(rx_active), .rx_error(rx_error),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .read_strobe(read_strobe),
    .read_data(read_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .clear_overflow(clear_overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    mode  = M_IDLE;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
  endtask

  // Drive one clock of inputs, advance the model by the same clock, sample 1 time unit after the edge.
  task automatic cycle(input bit act, input bit err, input logic [9:0] data,
                       input bit stb, input bit rd, input bit clr);
    bit push, do_pop, drop;
    logic [15:0] ent;
    rx_active = act; rx_error = err; rx_data = data;
    rx_strobe = stb; read_strobe = rd; clear_overflow = clr;
    push = 1'b0;
    ent  = {6'b0, data};
    m_fd = 1'b0;
    case (mode)
      M_IDLE: begin
        if (err) begin push = 1'b1; ent = {1'b1, 5'b0, data}; mode = M_ERR; end
        else if (act) mode = M_RECV;
      end
      M_RECV: begin
        if (err) begin push = 1'b1; ent = {1'b1, 5'b0, data}; mode = M_ERR; end
        else if (!act) begin m_fd = 1'b1; mode = M_IDLE; end
        else if (stb) push = 1'b1;
      end
      default: if (!err && !act) mode = M_IDLE;
    endcase
    do_pop = rd && q.size() > 0;
    drop   = push && q.size() == DEPTH && !rd;
    if (drop) begin m_ovf = 1'b1; mode = M_DISC; end
    else if (clr) m_ovf = 1'b0;
    if (do_pop) void'(q.pop_front());
    if (push && !drop) q.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    reset_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_frame();
    logic [15:0] exp_e [3];
    int fd_seen;
    exp_e[0] = 16'h0001; exp_e[1] = 16'h02AA; exp_e[2] = 16'h03FF;
    fd_seen = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 10'h001, 1, 0, 0);
    cycle(1, 0, 10'h000, 0, 0, 0);
    cycle(1, 0, 10'h2AA, 1, 0, 0);
    cycle(1, 0, 10'h3FF, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (frame_done === 1'b1) fd_seen++;
    end
    checks++; if (fd_seen != 1) begin errors++; $display("FAIL frame_done_pulses: got %0d expected 1", fd_seen); end
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL frame_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (read_data !== exp_e[i]) begin errors++; $display("FAIL frame_entry%0d: got %h expected %h", i, read_data, exp_e[i]); end
      cycle(0, 0, 0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frame_drained_empty: got %b expected 1", empty); end
  endtask

  task automatic test_error();
    int fd_seen;
    fd_seen = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 10'h155, 1, 0, 0);
    cycle(1, 1, 10'h002, 0, 0, 0);
    cycle(1, 1, 10'h0F0, 1, 0, 0);
    cycle(1, 1, 10'h0F1, 1, 0, 0);
    cycle(1, 0, 10'h0F2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (frame_done === 1'b1) fd_seen++;
    end
    checks++; if (fd_seen != 0) begin errors++; $display("FAIL error_no_frame_done: got %0d expected 0", fd_seen); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL error_count: got %0d expected 2", count); end
    checks++; if (read_data !== 16'h0155) begin errors++; $display("FAIL error_entry0: got %h expected 0155", read_data); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (read_data !== 16'h8002) begin errors++; $display("FAIL error_entry1: got %h expected 8002", read_data); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL error_drained: got %b expected 1", empty); end
  endtask

  task automatic test_overflow();
    int fd_seen;
    fd_seen = 0;
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) cycle(1, 0, 10'(i), 1, 0, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    cycle(1, 1, 10'h3AB, 1, 0, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_discard_ignores: got %0d expected 16", count); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      if (frame_done === 1'b1) fd_seen++;
    end
    checks++; if (fd_seen != 0) begin errors++; $display("FAIL ovf_no_frame_done: got %0d expected 0", fd_seen); end
    checks++; if (read_data !== 16'h0001) begin errors++; $display("FAIL ovf_head: got %h expected 0001", read_data); end
  endtask

  task automatic test_full_push_pop();
    cycle(0, 0, 0, 0, 0, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 10'h155, 1, 1, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpp_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %b expected 0", overflow); end
    checks++; if (read_data !== 16'h0002) begin errors++; $display("FAIL fullpp_head: got %h expected 0002", read_data); end
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (read_data !== q[0]) begin errors++; $display("FAIL fullpp_drain%0d: got %h expected %h", i, read_data, q[0]); end
      cycle(0, 0, 0, 0, 1, 0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_empty_ops();
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL empty_pop: got count %0d empty %b expected 0 1", count, empty); end
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 10'h0AB, 1, 1, 0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_pushpop_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0 || read_data !== 16'h00AB) begin errors++; $display("FAIL empty_pushpop_data: got %h empty %b expected 00ab 0", read_data, empty); end
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit act, err, stb, rd, clr;
    act = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) act = ~act;
      err = ($urandom_range(0, 39) == 0);
      stb = ($urandom_range(0, 1) == 1);
      rd  = (i % 200 < 120) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 19) == 0);
      cycle(act, err, 10'($urandom), stb, rd, clr);
      checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", i, count, q.size()); end
      checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_flags@%0d: got empty %b full %b size %0d", i, empty, full, q.size()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow@%0d: got %b expected %b", i, overflow, m_ovf); end
      checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL rand_frame_done@%0d: got %b expected %b", i, frame_done, m_fd); end
      if (q.size() > 0) begin
        checks++; if (read_data !== q[0]) begin errors++; $display("FAIL rand_data@%0d: got %h expected %h", i, read_data, q[0]); end
      end
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 10'(16 + i), 1, 0, 0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 5", count); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL midrst_async: got empty %b count %0d expected 1 0", empty, count); end
    checks++; if (overflow !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ovf %b full %b expected 0 0", overflow, full); end
    model_reset();
    reset_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 10'h111, 1, 0, 0);
    cycle(1, 0, 10'h222, 1, 0, 0);
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL midrst_resume_count: got %0d expected 2", count); end
    checks++; if (read_data !== 16'h0111) begin errors++; $display("FAIL midrst_resume_head: got %h expected 0111", read_data); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL midrst_frame_done: got %b expected 1", frame_done); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_error();
    test_overflow();
    test_full_push_pop();
    test_empty_ops();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
